// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the miniRV ID/EX stage: ALU opcodes, writeback selects,
// ALU B-source selects and the per-operand forward-select encoding.
package id_ex_stage_pkg;

  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_SUB  = 4'd1;
  localparam logic [3:0] ALU_OP_AND  = 4'd2;
  localparam logic [3:0] ALU_OP_OR   = 4'd3;
  localparam logic [3:0] ALU_OP_XOR  = 4'd4;
  localparam logic [3:0] ALU_OP_SLL  = 4'd5;
  localparam logic [3:0] ALU_OP_SRL  = 4'd6;
  localparam logic [3:0] ALU_OP_SRA  = 4'd7;
  localparam logic [3:0] ALU_OP_SLT  = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU = 4'd9;
  localparam logic [3:0] ALU_OP_LUI  = 4'd10;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic ALUB_SEL_RS2 = 1'b0;
  localparam logic ALUB_SEL_IMM = 1'b1;

  typedef enum logic [1:0] {
    FwdReg = 2'd0,
    FwdExm = 2'd1,
    FwdMwb = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational hazard detection and EX-time forward selection for id_ex_stage.
// ID_EX_FWD_EN: defined -> load-use detect + forward selects; undefined -> RAW stall.
module id_ex_hazard
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned RF_AW = 5
) (
  input  logic             id_valid,
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic             id_alub_sel,
  input  logic             id_mem_we,
  input  logic             ex_valid,
  input  logic [RF_AW-1:0] ex_rd,
  input  logic             exm_rf_we,
  input  logic [RF_AW-1:0] exm_rd,
`ifdef ID_EX_FWD_EN
  input  logic             ex_is_load,
  input  logic [RF_AW-1:0] ex_rs1,
  input  logic [RF_AW-1:0] ex_rs2,
  input  logic             mwb_rf_we,
  input  logic [RF_AW-1:0] mwb_rd,
  output fwd_sel_e         fwd_a,
  output fwd_sel_e         fwd_b,
`else
  input  logic             ex_rf_we,
`endif
  output logic             hazard
);

  // rs2 matters only when it feeds the ALU or supplies store data
  logic rs2_used;
  assign rs2_used = (id_alub_sel == ALUB_SEL_RS2) | id_mem_we;

`ifdef ID_EX_FWD_EN
  assign hazard = ex_valid & ex_is_load & (ex_rd != '0) & id_valid &
                  ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & rs2_used));

  always_comb begin
    fwd_a = FwdReg;
    if (exm_rf_we && exm_rd != '0 && exm_rd == ex_rs1) begin
      fwd_a = FwdExm;
    end else if (mwb_rf_we && mwb_rd != '0 && mwb_rd == ex_rs1) begin
      fwd_a = FwdMwb;
    end
  end

  always_comb begin
    fwd_b = FwdReg;
    if (exm_rf_we && exm_rd != '0 && exm_rd == ex_rs2) begin
      fwd_b = FwdExm;
    end else if (mwb_rf_we && mwb_rd != '0 && mwb_rd == ex_rs2) begin
      fwd_b = FwdMwb;
    end
  end
`else
  logic ex_hit, exm_hit;
  assign ex_hit  = ex_valid & ex_rf_we & (ex_rd != '0) &
                   ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & rs2_used));
  assign exm_hit = exm_rf_we & (exm_rd != '0) &
                   ((exm_rd == id_rs1) | ((exm_rd == id_rs2) & rs2_used));
  assign hazard  = id_valid & (ex_hit | exm_hit);
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture-time WB bypass, hazard bubbles and ALU operand delivery.
// ID_EX_FWD_EN enables EX-time EX/MEM and MEM/WB forwarding (otherwise RAW stalls are used).
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [RF_AW-1:0] id_rs1,
  input  logic [RF_AW-1:0] id_rs2,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RF_AW-1:0] id_rd,
  input  logic [3:0]       id_alu_op,
  input  logic             id_alub_sel,
  input  logic             id_rf_we,
  input  logic             id_mem_we,
  input  logic             id_is_load,
  input  logic [1:0]       id_wb_sel,
  input  logic             ex_flush,
  input  logic             mem_stall,
  input  logic             exm_rf_we,
  input  logic [RF_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]  exm_wd,
  input  logic             mwb_rf_we,
  input  logic [RF_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]  mwb_wd,
  output logic             id_stall,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_op,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_imm,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RF_AW-1:0] ex_rd,
  output logic             ex_rf_we,
  output logic             ex_mem_we,
  output logic             ex_is_load,
  output logic [1:0]       ex_wb_sel
);

  logic             valid_q, alub_sel_q, rf_we_q, mem_we_q, is_load_q;
  logic [XLEN-1:0]  pc_q, imm_q, rs1_val_q, rs2_val_q;
  logic [RF_AW-1:0] rd_q;
  logic [3:0]       alu_op_q;
  logic [1:0]       wb_sel_q;
  logic             hazard;
  logic [XLEN-1:0]  rs1_cap, rs2_cap, rs1_fwd, rs2_fwd;

  // Covers a regfile write landing in the same cycle as the ID read
  assign rs1_cap = (mwb_rf_we && mwb_rd != '0 && mwb_rd == id_rs1) ? mwb_wd : id_rs1_data;
  assign rs2_cap = (mwb_rf_we && mwb_rd != '0 && mwb_rd == id_rs2) ? mwb_wd : id_rs2_data;

`ifdef ID_EX_FWD_EN
  logic [RF_AW-1:0] rs1_q, rs2_q;
  fwd_sel_e         fwd_a, fwd_b;

  id_ex_hazard #(.RF_AW(RF_AW)) u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_alub_sel (id_alub_sel),
    .id_mem_we   (id_mem_we),
    .ex_valid    (valid_q),
    .ex_rd       (rd_q),
    .exm_rf_we   (exm_rf_we),
    .exm_rd      (exm_rd),
    .ex_is_load  (is_load_q),
    .ex_rs1      (rs1_q),
    .ex_rs2      (rs2_q),
    .mwb_rf_we   (mwb_rf_we),
    .mwb_rd      (mwb_rd),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .hazard      (hazard)
  );

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (!mem_stall && !ex_flush && !hazard) begin
      rs1_q <= id_rs1;
      rs2_q <= id_rs2;
    end
  end

  always_comb begin
    case (fwd_a)
      FwdExm:  rs1_fwd = exm_wd;
      FwdMwb:  rs1_fwd = mwb_wd;
      default: rs1_fwd = rs1_val_q;
    endcase
    case (fwd_b)
      FwdExm:  rs2_fwd = exm_wd;
      FwdMwb:  rs2_fwd = mwb_wd;
      default: rs2_fwd = rs2_val_q;
    endcase
  end
`else
  logic unused_exm_wd;
  assign unused_exm_wd = ^exm_wd;

  id_ex_hazard #(.RF_AW(RF_AW)) u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_alub_sel (id_alub_sel),
    .id_mem_we   (id_mem_we),
    .ex_valid    (valid_q),
    .ex_rd       (rd_q),
    .exm_rf_we   (exm_rf_we),
    .exm_rd      (exm_rd),
    .ex_rf_we    (rf_we_q),
    .hazard      (hazard)
  );

  assign rs1_fwd = rs1_val_q;
  assign rs2_fwd = rs2_val_q;
`endif

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      rd_q       <= '0;
      alu_op_q   <= ALU_OP_ADD;
      alub_sel_q <= ALUB_SEL_RS2;
      rf_we_q    <= 1'b0;
      mem_we_q   <= 1'b0;
      is_load_q  <= 1'b0;
      wb_sel_q   <= WB_SEL_ALU;
    end else if (mem_stall) begin
      valid_q <= valid_q;
    end else if (ex_flush || hazard) begin
      valid_q   <= 1'b0;
      rf_we_q   <= 1'b0;
      mem_we_q  <= 1'b0;
      is_load_q <= 1'b0;
    end else begin
      valid_q    <= id_valid;
      pc_q       <= id_pc;
      imm_q      <= id_imm;
      rs1_val_q  <= rs1_cap;
      rs2_val_q  <= rs2_cap;
      rd_q       <= id_rd;
      alu_op_q   <= id_alu_op;
      alub_sel_q <= id_alub_sel;
      rf_we_q    <= id_rf_we & id_valid;
      mem_we_q   <= id_mem_we & id_valid;
      is_load_q  <= id_is_load & id_valid;
      wb_sel_q   <= id_wb_sel;
    end
  end

  assign id_stall      = mem_stall | (~ex_flush & hazard);
  assign alu_a         = rs1_fwd;
  assign alu_b         = (alub_sel_q == ALUB_SEL_IMM) ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign alu_op        = alu_op_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_rf_we      = rf_we_q;
  assign ex_mem_we     = mem_we_q;
  assign ex_is_load    = is_load_q;
  assign ex_wb_sel     = wb_sel_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed ID/side-band vectors push expected EX state,
// a monitor compares after each rising edge.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        cpu_clk, cpu_rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alub_sel, id_rf_we, id_mem_we, id_is_load;
  logic [1:0]  id_wb_sel;
  logic        ex_flush, mem_stall;
  logic        exm_rf_we, mwb_rf_we;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_wd, mwb_wd;
  logic        id_stall;
  logic [31:0] alu_a, alu_b, ex_pc, ex_imm, ex_store_data;
  logic [3:0]  alu_op;
  logic        ex_valid, ex_rf_we, ex_mem_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;

  id_ex_stage dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_alub_sel(id_alub_sel),
    .id_rf_we(id_rf_we), .id_mem_we(id_mem_we), .id_is_load(id_is_load),
    .id_wb_sel(id_wb_sel), .ex_flush(ex_flush), .mem_stall(mem_stall),
    .exm_rf_we(exm_rf_we), .exm_rd(exm_rd), .exm_wd(exm_wd), .mwb_rf_we(mwb_rf_we),
    .mwb_rd(mwb_rd), .mwb_wd(mwb_wd), .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_rf_we(ex_rf_we),
    .ex_mem_we(ex_mem_we), .ex_is_load(ex_is_load), .ex_wb_sel(ex_wb_sel)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic valid; logic [31:0] pc; logic [4:0] rs1, rs2, rd;
    logic [31:0] d1, d2, imm; logic [3:0] op; logic bsel, rf, mw, ld; logic [1:0] wb;
  } id_t;

  typedef struct {
    logic flush, mstall, exm_we; logic [4:0] exm_rd; logic [31:0] exm_wd;
    logic mwb_we; logic [4:0] mwb_rd; logic [31:0] mwb_wd;
  } side_t;

  typedef struct {
    int tag; logic full; logic stall, valid; logic [31:0] pc, a, b, st;
    logic [4:0] rd; logic rf, mw, ld; logic [3:0] op; logic [1:0] wb;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag = 0;

  function automatic id_t mk(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                             logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                             logic [31:0] imm, logic [3:0] op, logic bsel, logic rf,
                             logic mw, logic ld, logic [1:0] wb);
    id_t i;
    i.valid = v; i.pc = pc; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.d1 = d1; i.d2 = d2;
    i.imm = imm; i.op = op; i.bsel = bsel; i.rf = rf; i.mw = mw; i.ld = ld; i.wb = wb;
    return i;
  endfunction

  function automatic side_t sd(logic fl, logic ms, logic ew, logic [4:0] er, logic [31:0] ed,
                               logic mwe, logic [4:0] mr, logic [31:0] md);
    side_t s;
    s.flush = fl; s.mstall = ms; s.exm_we = ew; s.exm_rd = er; s.exm_wd = ed;
    s.mwb_we = mwe; s.mwb_rd = mr; s.mwb_wd = md;
    return s;
  endfunction

  function automatic exp_t ex_full(logic stall, logic [31:0] pc, logic [31:0] a,
                                   logic [31:0] b, logic [31:0] st, logic [4:0] rd,
                                   logic rf, logic mw, logic ld, logic [3:0] op,
                                   logic [1:0] wb);
    exp_t e;
    e.tag = 0; e.full = 1'b1; e.stall = stall; e.valid = 1'b1; e.pc = pc; e.a = a; e.b = b;
    e.st = st; e.rd = rd; e.rf = rf; e.mw = mw; e.ld = ld; e.op = op; e.wb = wb;
    return e;
  endfunction

  function automatic exp_t ex_bub(logic stall);
    exp_t e;
    e = ex_full(stall, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, ALU_OP_ADD, WB_SEL_ALU);
    e.full = 1'b0; e.valid = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input id_t i, input side_t s, input exp_t e);
    @(negedge cpu_clk);
    #1;
    id_valid = i.valid; id_pc = i.pc; id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
    id_rs1_data = i.d1; id_rs2_data = i.d2; id_imm = i.imm; id_alu_op = i.op;
    id_alub_sel = i.bsel; id_rf_we = i.rf; id_mem_we = i.mw; id_is_load = i.ld;
    id_wb_sel = i.wb;
    ex_flush = s.flush; mem_stall = s.mstall;
    exm_rf_we = s.exm_we; exm_rd = s.exm_rd; exm_wd = s.exm_wd;
    mwb_rf_we = s.mwb_we; mwb_rd = s.mwb_rd; mwb_wd = s.mwb_wd;
    tag++;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) break;
      @(posedge cpu_clk);
    end
    #2;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: id_stall sampled before the edge, EX state sampled just after it
  initial begin
    exp_t e;
    logic st;
    forever begin
      @(negedge cpu_clk);
      #2;
      if (q.size() > 0) begin
        e  = q[0];
        st = id_stall;
        @(posedge cpu_clk);
        #1;
        chk($sformatf("v%0d id_stall", e.tag), {31'd0, st}, {31'd0, e.stall});
        chk($sformatf("v%0d ex_valid", e.tag), {31'd0, ex_valid}, {31'd0, e.valid});
        chk($sformatf("v%0d ex_rf_we", e.tag), {31'd0, ex_rf_we}, {31'd0, e.rf});
        chk($sformatf("v%0d ex_mem_we", e.tag), {31'd0, ex_mem_we}, {31'd0, e.mw});
        chk($sformatf("v%0d ex_is_load", e.tag), {31'd0, ex_is_load}, {31'd0, e.ld});
        if (e.full) begin
          chk($sformatf("v%0d ex_pc", e.tag), ex_pc, e.pc);
          chk($sformatf("v%0d alu_a", e.tag), alu_a, e.a);
          chk($sformatf("v%0d alu_b", e.tag), alu_b, e.b);
          chk($sformatf("v%0d ex_store_data", e.tag), ex_store_data, e.st);
          chk($sformatf("v%0d ex_rd", e.tag), {27'd0, ex_rd}, {27'd0, e.rd});
          chk($sformatf("v%0d alu_op", e.tag), {28'd0, alu_op}, {28'd0, e.op});
          chk($sformatf("v%0d ex_wb_sel", e.tag), {30'd0, ex_wb_sel}, {30'd0, e.wb});
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    side_t ns;
    id_t   dep;
    ns = sd(0, 0, 0, 0, 0, 0, 0, 0);
    cpu_rst = 1'b1;
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0;
    id_rs2_data = 0; id_imm = 0; id_alu_op = 0; id_alub_sel = 0; id_rf_we = 0;
    id_mem_we = 0; id_is_load = 0; id_wb_sel = 0; ex_flush = 0; mem_stall = 0;
    exm_rf_we = 0; exm_rd = 0; exm_wd = 0; mwb_rf_we = 0; mwb_rd = 0; mwb_wd = 0;
    #7;
    chk("reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset alu_a", alu_a, 32'd0);
    chk("reset alu_b", alu_b, 32'd0);
    chk("reset alu_op", {28'd0, alu_op}, {28'd0, ALU_OP_ADD});
    chk("reset ex_rf_we", {31'd0, ex_rf_we}, 32'd0);
    chk("reset id_stall", {31'd0, id_stall}, 32'd0);
    #1 cpu_rst = 1'b0;

    // Mid-operation reset discards the EX instruction without waiting for an edge
    step(mk(1, 32'h80, 1, 2, 3, 32'h1111, 32'h2222, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h80, 32'h1111, 32'h2222, 32'h2222, 3, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    drain();
    @(negedge cpu_clk);
    #3 cpu_rst = 1'b1;
    #1;
    chk("async reset ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("async reset alu_a", alu_a, 32'd0);
    chk("async reset alu_b", alu_b, 32'd0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    id_valid = 1'b0;

    // Plain captures: I-type, R-type, invalid with control bits set, store
    step(mk(1, 32'h100, 2, 0, 1, 32'h10, 32'h99, 5, ALU_OP_ADD, 1, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h100, 32'h10, 5, 32'h99, 1, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    step(mk(1, 32'h104, 4, 6, 3, 100, 30, 7, ALU_OP_SUB, 0, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h104, 100, 30, 30, 3, 1, 0, 0, ALU_OP_SUB, WB_SEL_ALU));
    step(mk(0, 32'h108, 4, 6, 3, 1, 2, 3, ALU_OP_OR, 0, 1, 1, 1, WB_SEL_MEM), ns, ex_bub(0));
    step(mk(1, 32'h10C, 8, 7, 0, 32'h2000, 32'hCAFE, 32'h10, ALU_OP_ADD, 1, 0, 1, 0, WB_SEL_ALU),
         ns, ex_full(0, 32'h10C, 32'h2000, 32'h10, 32'hCAFE, 0, 0, 1, 0, ALU_OP_ADD, WB_SEL_ALU));
    // Capture-time WB bypass on rs1, then x0 never bypassed
    step(mk(1, 32'h110, 9, 10, 11, 0, 32'h22, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU),
         sd(0, 0, 0, 0, 0, 1, 9, 32'h5555),
         ex_full(0, 32'h110, 32'h5555, 32'h22, 32'h22, 11, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    step(mk(1, 32'h114, 0, 12, 13, 32'h77, 3, 4, ALU_OP_ADD, 1, 1, 0, 1, WB_SEL_MEM),
         sd(0, 0, 0, 0, 0, 1, 0, 32'hDEAD),
         ex_full(0, 32'h114, 32'h77, 4, 3, 13, 1, 0, 1, ALU_OP_ADD, WB_SEL_MEM));
    // Dependent on the load in EX while flushed: bubble, flush suppresses id_stall
    step(mk(1, 32'h118, 13, 14, 15, 1, 2, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU),
         sd(1, 0, 0, 0, 0, 0, 0, 0), ex_bub(0));
    step(mk(1, 32'h120, 15, 16, 14, 7, 8, 0, ALU_OP_XOR, 0, 1, 0, 0, WB_SEL_PC4), ns,
         ex_full(0, 32'h120, 7, 8, 8, 14, 1, 0, 0, ALU_OP_XOR, WB_SEL_PC4));
    // Three cycles of mem_stall: EX frozen, id_stall high
    for (int k = 0; k < 3; k++) begin
      step(mk(1, 32'h124, 14, 2, 5, 32'hFFFF, 32'hEEEE, 9, ALU_OP_SUB, 1, 1, 1, 0, WB_SEL_MEM),
           sd(0, 1, 0, 0, 0, 0, 0, 0),
           ex_full(1, 32'h120, 7, 8, 8, 14, 1, 0, 0, ALU_OP_XOR, WB_SEL_PC4));
    end
    step(mk(1, 32'h128, 17, 18, 19, 1, 2, 0, ALU_OP_OR, 0, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h128, 1, 2, 2, 19, 1, 0, 0, ALU_OP_OR, WB_SEL_ALU));

`ifdef ID_EX_FWD_EN
    // EX/MEM forward over stale rs1 data
    step(mk(1, 32'h12C, 5, 7, 6, 0, 1, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU),
         sd(0, 0, 1, 5, 32'h1234, 0, 0, 0),
         ex_full(0, 32'h12C, 32'h1234, 1, 1, 6, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // EX/MEM beats MEM/WB
    step(mk(1, 32'h130, 5, 7, 6, 0, 2, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU),
         sd(0, 0, 1, 5, 32'hAAAA, 1, 5, 32'hBBBB),
         ex_full(0, 32'h130, 32'hAAAA, 2, 2, 6, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // Load-use: one bubble, then the load result arrives via EX/MEM
    step(mk(1, 32'h134, 2, 0, 5, 32'h300, 0, 8, ALU_OP_ADD, 1, 1, 0, 1, WB_SEL_MEM), ns,
         ex_full(0, 32'h134, 32'h300, 8, 0, 5, 1, 0, 1, ALU_OP_ADD, WB_SEL_MEM));
    dep = mk(1, 32'h138, 5, 7, 6, 0, 3, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU);
    step(dep, ns, ex_bub(1));
    step(dep, sd(0, 0, 1, 5, 32'h4242, 0, 0, 0),
         ex_full(0, 32'h138, 32'h4242, 3, 3, 6, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // Store data depending on a load: stall, then forward from MEM/WB
    step(mk(1, 32'h13C, 2, 0, 8, 32'h400, 0, 4, ALU_OP_ADD, 1, 1, 0, 1, WB_SEL_MEM), ns,
         ex_full(0, 32'h13C, 32'h400, 4, 0, 8, 1, 0, 1, ALU_OP_ADD, WB_SEL_MEM));
    dep = mk(1, 32'h140, 3, 8, 0, 32'h500, 0, 12, ALU_OP_ADD, 1, 0, 1, 0, WB_SEL_ALU);
    step(dep, ns, ex_bub(1));
    step(dep, sd(0, 0, 0, 0, 0, 1, 8, 32'h99),
         ex_full(0, 32'h140, 32'h500, 12, 32'h99, 0, 0, 1, 0, ALU_OP_ADD, WB_SEL_ALU));
`else
    // RAW on the ALU result in EX: two stall cycles, then capture through the WB bypass
    dep = mk(1, 32'h12C, 19, 21, 20, 0, 5, 0, ALU_OP_ADD, 0, 1, 0, 0, WB_SEL_ALU);
    step(dep, ns, ex_bub(1));
    step(dep, sd(0, 0, 1, 19, 32'h33, 0, 0, 0), ex_bub(1));
    step(dep, sd(0, 0, 0, 0, 0, 1, 19, 32'h33),
         ex_full(0, 32'h12C, 32'h33, 5, 5, 20, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // rs2 ignored when B is the immediate and no store
    step(mk(1, 32'h130, 22, 20, 23, 32'h44, 32'h55, 9, ALU_OP_ADD, 1, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h130, 32'h44, 9, 32'h55, 23, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // Store data rs2 is a used source
    step(mk(1, 32'h134, 1, 23, 0, 32'h60, 32'h61, 4, ALU_OP_ADD, 1, 0, 1, 0, WB_SEL_ALU), ns,
         ex_bub(1));
    step(mk(1, 32'h138, 1, 2, 0, 32'h11, 32'h22, 32'h40, ALU_OP_ADD, 1, 1, 0, 0, WB_SEL_ALU),
         ns, ex_full(0, 32'h138, 32'h11, 32'h40, 32'h22, 0, 1, 0, 0, ALU_OP_ADD, WB_SEL_ALU));
    // rd = x0 in EX is never a hazard source
    step(mk(1, 32'h13C, 0, 3, 4, 32'h66, 32'h67, 0, ALU_OP_AND, 0, 1, 0, 0, WB_SEL_ALU), ns,
         ex_full(0, 32'h13C, 32'h66, 32'h67, 32'h67, 4, 1, 0, 0, ALU_OP_AND, WB_SEL_ALU));
`endif
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
